// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM arbiter: FSM encoding, owner codes, default widths.
package sdram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_BURST = 2'd2
  } arb_state_t;

  localparam logic OWNER_VIDEO = 1'b0;
  localparam logic OWNER_MMU   = 1'b1;

  localparam int unsigned DEF_ADDR_W     = 32;
  localparam int unsigned DEF_DATA_W     = 16;
  localparam int unsigned DEF_STARVE_MAX = 4;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of video grants that were made while the MMU was waiting.
// Instantiated by sdram_arbiter only when SDRAM_ARB_FAIRNESS_EN is defined.
module arb_starve_cnt #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic cache_clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic starved_c
);

  localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] count;

  assign starved_c = (count >= CNT_W'(STARVE_MAX));

  // Count video wins over a waiting MMU; an MMU grant wipes the history.
  always_ff @(posedge cache_clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !starved_c) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Two-master (video read / MMU read-write) arbiter in front of an SDRAM controller.
// Video has priority; define SDRAM_ARB_FAIRNESS_EN to let the MMU through after
// STARVE_MAX consecutive video grants that kept it waiting.
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic              cache_clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] v_address,
  input  logic              v_rw_req,
  input  logic              v_burst_len,
  output logic              v_bursting,
  input  logic [ADDR_W-1:0] m_address,
  input  logic              m_rw_req,
  input  logic              m_rw,
  input  logic [DATA_W-1:0] m_write_data,
  input  logic              m_burst_len,
  output logic              m_bursting,
  output logic [ADDR_W-1:0] sd_address,
  output logic              sd_rw_req,
  output logic              sd_rw,
  output logic [DATA_W-1:0] sd_write_data,
  output logic              sd_burst_len,
  input  logic              sd_bursting,
  output logic              owner
);

  arb_state_t state;
  logic       owner_req_c;
  logic       starved_c;
  logic       grant_video_c;
  logic       grant_mmu_c;

  assign owner_req_c   = (owner == OWNER_MMU) ? m_rw_req : v_rw_req;
  assign grant_video_c = v_rw_req && !(starved_c && m_rw_req);
  assign grant_mmu_c   = m_rw_req && !grant_video_c;

`ifdef SDRAM_ARB_FAIRNESS_EN
  logic starve_inc_c;
  logic starve_clr_c;

  assign starve_inc_c = (state == ST_IDLE) && grant_video_c && m_rw_req;
  assign starve_clr_c = (state == ST_IDLE) && grant_mmu_c;

  arb_starve_cnt #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .cache_clk (cache_clk),
    .reset     (reset),
    .inc       (starve_inc_c),
    .clr       (starve_clr_c),
    .starved_c (starved_c)
  );
`else
  logic unused_starve_max;

  assign starved_c         = 1'b0;
  assign unused_starve_max = ^32'(STARVE_MAX);
`endif

  // Controller-side mux follows the owner register only, never the live requests.
  assign sd_address    = (owner == OWNER_MMU) ? m_address : v_address;
  assign sd_rw         = (owner == OWNER_MMU) & m_rw;
  assign sd_burst_len  = (owner == OWNER_MMU) ? m_burst_len : v_burst_len;
  assign sd_write_data = m_write_data;

  // Data-phase indicator steered to whichever master owns the bus.
  assign v_bursting = sd_bursting & (owner == OWNER_VIDEO);
  assign m_bursting = sd_bursting & (owner == OWNER_MMU);

  // Arbitration FSM: owner only moves in IDLE; a transaction ends on abort or burst end.
  always_ff @(posedge cache_clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      owner     <= OWNER_VIDEO;
      sd_rw_req <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_video_c) begin
            owner     <= OWNER_VIDEO;
            sd_rw_req <= 1'b1;
            state     <= ST_REQ;
          end else if (grant_mmu_c) begin
            owner     <= OWNER_MMU;
            sd_rw_req <= 1'b1;
            state     <= ST_REQ;
          end else begin
            sd_rw_req <= 1'b0;
          end
        end
        ST_REQ: begin
          sd_rw_req <= owner_req_c;
          if (sd_bursting) begin
            state <= ST_BURST;
          end else if (!owner_req_c) begin
            state <= ST_IDLE;
          end
        end
        ST_BURST: begin
          if (!sd_bursting) begin
            sd_rw_req <= 1'b0;
            state     <= ST_IDLE;
          end else begin
            sd_rw_req <= owner_req_c;
          end
        end
        default: begin
          sd_rw_req <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level arbitration model.
module tb_sdram_arbiter;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned STARVE_MAX = 4;
`ifdef SDRAM_ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic              cache_clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] v_address;
  logic              v_rw_req;
  logic              v_burst_len;
  logic              v_bursting;
  logic [ADDR_W-1:0] m_address;
  logic              m_rw_req;
  logic              m_rw;
  logic [DATA_W-1:0] m_write_data;
  logic              m_burst_len;
  logic              m_bursting;
  logic [ADDR_W-1:0] sd_address;
  logic              sd_rw_req;
  logic              sd_rw;
  logic [DATA_W-1:0] sd_write_data;
  logic              sd_burst_len;
  logic              sd_bursting;
  logic              owner;

  int checks = 0;
  int errors = 0;
  int starve = 0;

  sdram_arbiter #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .cache_clk     (cache_clk),
    .reset         (reset),
    .v_address     (v_address),
    .v_rw_req      (v_rw_req),
    .v_burst_len   (v_burst_len),
    .v_bursting    (v_bursting),
    .m_address     (m_address),
    .m_rw_req      (m_rw_req),
    .m_rw          (m_rw),
    .m_write_data  (m_write_data),
    .m_burst_len   (m_burst_len),
    .m_bursting    (m_bursting),
    .sd_address    (sd_address),
    .sd_rw_req     (sd_rw_req),
    .sd_rw         (sd_rw),
    .sd_write_data (sd_write_data),
    .sd_burst_len  (sd_burst_len),
    .sd_bursting   (sd_bursting),
    .owner         (owner)
  );

  always #5 cache_clk = ~cache_clk;

  task automatic tick();
    @(posedge cache_clk);
    #1;
  endtask

  // Arbitration rule: video wins unless the MMU has been passed over STARVE_MAX times.
  task automatic model_decide(input logic v, input logic m, output logic own);
    if (v && !(FAIR && (starve >= int'(STARVE_MAX)) && m)) begin
      own = 1'b0;
      if (m && starve < int'(STARVE_MAX)) starve = starve + 1;
    end else begin
      own = 1'b1;
      starve = 0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; v_rw_req = 1'b0; m_rw_req = 1'b0; sd_bursting = 1'b1; m_rw = 1'b1;
    v_address = 32'h0; m_address = 32'h0; m_write_data = 16'h0;
    v_burst_len = 1'b0; m_burst_len = 1'b0;
    tick(); tick();
    starve = 0;
    checks++; if (owner !== 1'b0) begin errors++; $display("FAIL reset_owner got %0b want 0", owner); end
    checks++; if (sd_rw_req !== 1'b0) begin errors++; $display("FAIL reset_req got %0b want 0", sd_rw_req); end
    checks++; if (sd_rw !== 1'b0) begin errors++; $display("FAIL reset_rw got %0b want 0", sd_rw); end
    checks++; if (v_bursting !== 1'b1 || m_bursting !== 1'b0) begin
      errors++; $display("FAIL reset_bursting got v=%0b m=%0b want v=1 m=0", v_bursting, m_bursting);
    end
    sd_bursting = 1'b0; m_rw = 1'b0; reset = 1'b1;
    tick();
    checks++; if (sd_rw_req !== 1'b0) begin errors++; $display("FAIL reset_idle_req got %0b want 0", sd_rw_req); end
  endtask

  // One arbitrated transaction; burst_cycles == 0 means the owner aborts in REQ.
  task automatic do_txn(input string name, input logic v, input logic m,
                        input logic [ADDR_W-1:0] va, input logic [ADDR_W-1:0] ma,
                        input logic [DATA_W-1:0] md, input logic mdir,
                        input logic vbl, input logic mbl, input int burst_cycles);
    logic exp;
    logic [ADDR_W-1:0] exp_addr;
    v_address = va; m_address = ma; m_write_data = md; m_rw = mdir;
    v_burst_len = vbl; m_burst_len = mbl;
    v_rw_req = v; m_rw_req = m;
    model_decide(v, m, exp);
    exp_addr = exp ? ma : va;
    tick();
    checks++; if (owner !== exp) begin errors++; $display("FAIL %s grant_owner got %0b want %0b", name, owner, exp); end
    checks++; if (sd_rw_req !== 1'b1) begin errors++; $display("FAIL %s grant_req got %0b want 1", name, sd_rw_req); end
    checks++; if (sd_address !== exp_addr) begin errors++; $display("FAIL %s grant_addr got %h want %h", name, sd_address, exp_addr); end
    checks++; if (sd_rw !== (exp & mdir)) begin errors++; $display("FAIL %s grant_rw got %0b want %0b", name, sd_rw, exp & mdir); end
    checks++; if (sd_burst_len !== (exp ? mbl : vbl)) begin errors++; $display("FAIL %s grant_bl got %0b want %0b", name, sd_burst_len, exp ? mbl : vbl); end
    checks++; if (sd_write_data !== md) begin errors++; $display("FAIL %s grant_wdata got %h want %h", name, sd_write_data, md); end
    if (burst_cycles == 0) begin
      v_rw_req = 1'b0; m_rw_req = 1'b0;
      tick();
      checks++; if (sd_rw_req !== 1'b0) begin errors++; $display("FAIL %s abort_req got %0b want 0", name, sd_rw_req); end
      sd_bursting = 1'b1;
      #1;
      checks++; if (owner !== exp) begin errors++; $display("FAIL %s abort_owner got %0b want %0b", name, owner, exp); end
      sd_bursting = 1'b0;
      tick();
      checks++; if (sd_rw_req !== 1'b0) begin errors++; $display("FAIL %s abort_idle got %0b want 0", name, sd_rw_req); end
    end else begin
      sd_bursting = 1'b1;
      for (int i = 0; i < burst_cycles; i++) begin
        tick();
        checks++; if (owner !== exp) begin errors++; $display("FAIL %s burst_owner got %0b want %0b", name, owner, exp); end
        checks++; if (sd_rw_req !== 1'b1) begin errors++; $display("FAIL %s burst_req got %0b want 1", name, sd_rw_req); end
        checks++; if (v_bursting !== ~exp || m_bursting !== exp) begin
          errors++; $display("FAIL %s burst_route got v=%0b m=%0b want v=%0b m=%0b", name, v_bursting, m_bursting, ~exp, exp);
        end
        checks++; if (sd_address !== exp_addr) begin errors++; $display("FAIL %s burst_addr got %h want %h", name, sd_address, exp_addr); end
        // Non-owner activity must not disturb the transaction.
        if (exp) begin v_rw_req = 1'($urandom); v_address = $urandom; end
        else begin m_rw_req = 1'($urandom); m_address = $urandom; end
      end
      sd_bursting = 1'b0; v_rw_req = 1'b0; m_rw_req = 1'b0;
      tick();
      checks++; if (sd_rw_req !== 1'b0) begin errors++; $display("FAIL %s end_req got %0b want 0", name, sd_rw_req); end
      checks++; if (owner !== exp) begin errors++; $display("FAIL %s end_owner got %0b want %0b", name, owner, exp); end
    end
  endtask

  task automatic test_priority();
    do_txn("both_req", 1'b1, 1'b1, 32'hA5A5_0001, 32'h5A5A_0002, 16'h1111, 1'b1, 1'b1, 1'b0, 0);
  endtask

  task automatic test_mmu_write();
    do_txn("mmu_write", 1'b0, 1'b1, 32'hDEAD_0000, 32'h0000_1234, 16'hBEEF, 1'b1, 1'b0, 1'b1, 8);
  endtask

  task automatic test_abort();
    do_txn("mmu_abort", 1'b0, 1'b1, 32'h0, 32'h0000_4000, 16'h0F0F, 1'b0, 1'b0, 1'b0, 0);
  endtask

  // Video waits through an MMU burst and is granted after exactly one IDLE cycle.
  task automatic test_back_to_back();
    logic exp;
    v_address = 32'h0000_0777; m_address = 32'h0000_0888; m_rw = 1'b0;
    v_rw_req = 1'b0; m_rw_req = 1'b1;
    model_decide(1'b0, 1'b1, exp);
    tick();
    v_rw_req = 1'b1;
    sd_bursting = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (owner !== 1'b1) begin errors++; $display("FAIL b2b_hold got %0b want 1", owner); end
    end
    sd_bursting = 1'b0; m_rw_req = 1'b0;
    tick();
    checks++; if (sd_rw_req !== 1'b0 || owner !== 1'b1) begin
      errors++; $display("FAIL b2b_gap got req=%0b owner=%0b want req=0 owner=1", sd_rw_req, owner);
    end
    model_decide(1'b1, 1'b0, exp);
    tick();
    checks++; if (sd_rw_req !== 1'b1 || owner !== exp || sd_address !== v_address) begin
      errors++; $display("FAIL b2b_video got req=%0b owner=%0b addr=%h want req=1 owner=%0b addr=%h",
                         sd_rw_req, owner, sd_address, exp, v_address);
    end
    v_rw_req = 1'b0;
    tick();
    checks++; if (sd_rw_req !== 1'b0) begin errors++; $display("FAIL b2b_abort got %0b want 0", sd_rw_req); end
  endtask

  task automatic test_reset_mid_burst();
    logic exp;
    m_address = 32'h0000_2222; m_rw = 1'b1; v_rw_req = 1'b0; m_rw_req = 1'b1;
    model_decide(1'b0, 1'b1, exp);
    tick();
    sd_bursting = 1'b1;
    tick(); tick();
    checks++; if (m_bursting !== 1'b1) begin errors++; $display("FAIL rst_burst_pre got %0b want 1", m_bursting); end
    reset = 1'b0;
    tick();
    starve = 0;
    checks++; if (owner !== 1'b0 || sd_rw_req !== 1'b0 || m_bursting !== 1'b0 || sd_rw !== 1'b0) begin
      errors++; $display("FAIL rst_burst got owner=%0b req=%0b mb=%0b rw=%0b want 0 0 0 0", owner, sd_rw_req, m_bursting, sd_rw);
    end
    reset = 1'b1; sd_bursting = 1'b0; m_rw_req = 1'b0; v_rw_req = 1'b1;
    model_decide(1'b1, 1'b0, exp);
    tick();
    checks++; if (sd_rw_req !== 1'b1 || owner !== exp) begin
      errors++; $display("FAIL rst_burst_regrant got req=%0b owner=%0b want req=1 owner=%0b", sd_rw_req, owner, exp);
    end
    v_rw_req = 1'b0;
    tick();
  endtask

  // Both masters request continuously; with fairness every fifth grant is the MMU.
  task automatic test_fairness();
    logic exp;
    logic want;
    reset = 1'b0; tick(); reset = 1'b1; starve = 0;
    tick();
    v_rw_req = 1'b1; m_rw_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      model_decide(1'b1, 1'b1, exp);
      want = FAIR && ((i % 5) == 4);
      tick();
      checks++; if (owner !== want) begin errors++; $display("FAIL fair_grant%0d got %0b want %0b", i, owner, want); end
      sd_bursting = 1'b1;
      tick();
      sd_bursting = 1'b0;
      tick();
    end
    v_rw_req = 1'b0; m_rw_req = 1'b0;
    tick();
  endtask

  task automatic test_random();
    int kind;
    for (int n = 0; n < 150; n++) begin
      kind = int'($urandom_range(1, 3));
      do_txn("random", kind != 2, kind != 1, $urandom, $urandom, 16'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom), int'($urandom_range(0, 6)));
    end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_mmu_write();
    test_abort();
    test_back_to_back();
    test_reset_mid_burst();
    test_fairness();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32: address width of all ports.
REQ-002 Parameter DATA_W, default 16: SDRAM data width.
REQ-003 Parameter STARVE_MAX, default 4: consecutive video grants tolerated while MMU waits (fairness only).
REQ-004 cache_clk  in  1  clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-low.
REQ-006 v_address  in  ADDR_W  video read address.
REQ-007 v_rw_req  in  1  video request (read only).
REQ-008 v_burst_len  in  1  video burst length select.
REQ-009 v_bursting  out  1  sd_bursting gated to video owner.
REQ-010 m_address  in  ADDR_W  MMU address.
REQ-011 m_rw_req  in  1  MMU request.
REQ-012 m_rw  in  1  MMU direction, 1=write.
REQ-013 m_write_data  in  DATA_W  MMU write data.
REQ-014 m_burst_len  in  1  MMU burst length select.
REQ-015 m_bursting  out  1  sd_bursting gated to MMU owner.
REQ-016 sd_address  out  ADDR_W  muxed address to SDRAM controller.
REQ-017 sd_rw_req  out  1  registered request to SDRAM controller.
REQ-018 sd_rw  out  1  muxed direction; 0 when video owns.
REQ-019 sd_write_data  out  DATA_W  m_write_data passthrough.
REQ-020 sd_burst_len  out  1  muxed burst length.
REQ-021 sd_bursting  in  1  controller data-phase indicator.
REQ-022 owner  out  1  current owner, 0=video, 1=MMU.

Function
REQ-023 FSM states IDLE, REQ, BURST; owner register changes only in IDLE.
REQ-024 IDLE, v_rw_req=1: next cycle owner=0, sd_rw_req=1, state REQ (video priority).
REQ-025 IDLE, v_rw_req=0 and m_rw_req=1: next cycle owner=1, sd_rw_req=1, state REQ.
REQ-026 IDLE, both low: remain IDLE, sd_rw_req=0, owner unchanged.
REQ-027 REQ: sd_rw_req registers owner's request each cycle; sd_bursting=1 -> BURST; owner request low before sd_bursting -> IDLE (abort, sd_rw_req=0 next cycle).
REQ-028 BURST: sd_rw_req tracks owner's request; sd_bursting falling (1->0) -> IDLE; minimum one IDLE cycle between grants.
REQ-029 sd_address, sd_rw, sd_burst_len: combinational mux on owner register only, never on live requests.
REQ-030 v_bursting = sd_bursting & ~owner; m_bursting = sd_bursting & owner; never both 1.
REQ-031 Non-owner request changes mid-transaction: ignored until IDLE.
REQ-032 Simultaneous v/m requests in IDLE: video wins unless fairness override (REQ-037) active.
REQ-033 Latency: request high in IDLE -> sd_rw_req high exactly 1 cycle later.

Reset
REQ-034 reset=0 at a clock edge: state=IDLE, owner=0, sd_rw_req=0, starve counter=0, regardless of state (mid-burst included).
REQ-035 During/after reset v_bursting, m_bursting follow REQ-030 with owner=0; sd_rw=0.

Configuration
REQ-036 Macro SDRAM_ARB_FAIRNESS_EN selects starvation protection.
REQ-037 Defined: counter increments per video grant from IDLE while m_rw_req=1, clears on MMU grant; at STARVE_MAX the next IDLE decision grants MMU if m_rw_req=1.
REQ-038 Undefined: strict video priority; counter not built; STARVE_MAX unused.

Structure
REQ-039 Shared package sdram_pkg: FSM state encoding, OWNER_VIDEO/OWNER_MMU constants, default widths.
REQ-040 Single module; starvation counter as sub-module arb_starve_cnt only when SDRAM_ARB_FAIRNESS_EN defined.

Verification
REQ-041 Reset mid-BURST (MMU owner) -> next cycle state IDLE, owner=0, sd_rw_req=0, m_bursting=0.
REQ-042 v_rw_req=1, m_rw_req=1 same cycle in IDLE -> owner=0, sd_rw_req=1 after 1 cycle, sd_rw=0, sd_address=v_address.
REQ-043 MMU write, m_address=0x00001234, m_write_data=0xBEEF, sd_bursting 1 for 8 cycles -> sd_address=0x00001234, sd_rw=1, m_bursting high 8 cycles, v_bursting 0 throughout.
REQ-044 Video requests during MMU BURST -> no owner change until sd_bursting falls; video granted after one IDLE cycle.
REQ-045 MMU drops m_rw_req in REQ before sd_bursting -> IDLE next cycle, sd_rw_req=0, no burst routed.
REQ-046 SDRAM_ARB_FAIRNESS_EN, STARVE_MAX=4, both requesting continuously -> grants V,V,V,V,M,V,V,V,V,M; without macro all grants V.
